// File: rtl/decoder_scan_if.sv
// decoder_scan_if: control inputs and decoded outputs of decoder_scan.
interface decoder_scan_if #(
    parameter int W = 3
);
    logic            en;
    logic            mode;
    logic            load;
    logic [W-1:0]    x;
    logic [2**W-1:0] y;
    logic [W-1:0]    idx;
    logic            wrap;
    modport master(output en, mode, x, load, input y, idx, wrap);
    modport slave(input en, mode, x, load, output y, idx, wrap);
endinterface

// File: rtl/decoder_scan.sv
// decoder_scan: registered W-to-2**W one-hot decoder with an auto-scan mode
// that steps through every code, holding each one for DWELL cycles.
module decoder_scan #(
    parameter int W     = 3,
    parameter int DWELL = 4
) (
    input logic           clk,
    input logic           rst,
    decoder_scan_if.slave bus
);
    localparam int N  = 2 ** W;
    localparam int CW = $clog2(DWELL + 1);
    typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;
    state_t        state;
    logic [CW-1:0] dcnt;
    logic [W-1:0]  idx;
    logic [W-1:0]  nxt;
    logic [N-1:0]  y;
    logic          wrap;
    // The mode needs no register of its own: idx/dcnt carry all scan progress.
    assign state = !bus.en ? IDLE : (bus.mode ? SCAN : DIRECT);
    assign nxt   = idx + W'(1);
    always_ff @(posedge clk) begin
        if (!rst) begin
            y    <= '0;
            idx  <= '0;
            dcnt <= '0;
            wrap <= 1'b0;
        end else if (state == IDLE) begin
            y    <= '0;
            wrap <= 1'b0;
        end else if (state == DIRECT || bus.load) begin
            idx  <= bus.x;
            y    <= N'(1) << bus.x;
            dcnt <= '0;
            wrap <= 1'b0;
        end else if (dcnt != CW'(DWELL - 1)) begin
            dcnt <= dcnt + CW'(1);
            y    <= N'(1) << idx;
            wrap <= 1'b0;
        end else begin
            dcnt <= '0;
            idx  <= nxt;
            y    <= N'(1) << nxt;
            wrap <= idx == {W{1'b1}};
        end
    end
    assign bus.y    = y;
    assign bus.idx  = idx;
    assign bus.wrap = wrap;
endmodule

// File: tb/tb_decoder_scan.sv
// tb_decoder_scan: directed vectors on four decoder_scan configurations, checked
// through an expected-response queue drained by an independent monitor.
module tb_decoder_scan;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       mode = 1'b0;
    logic       load = 1'b0;
    logic [2:0] x = '0;
    int         vectors = 0;
    int         miscompares = 0;

    typedef struct {
        int         sel;
        logic [7:0] y;
        logic [2:0] idx;
        logic       wrap;
        string      name;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    decoder_scan_if #(.W(3)) ia ();
    decoder_scan_if #(.W(2)) ib ();
    decoder_scan_if #(.W(2)) ic ();
    decoder_scan_if #(.W(3)) id ();
    assign ia.en = en; assign ia.mode = mode; assign ia.load = load; assign ia.x = x;
    assign ib.en = en; assign ib.mode = mode; assign ib.load = load; assign ib.x = x[1:0];
    assign ic.en = en; assign ic.mode = mode; assign ic.load = load; assign ic.x = x[1:0];
    assign id.en = en; assign id.mode = mode; assign id.load = load; assign id.x = x;

    decoder_scan #(.W(3), .DWELL(4)) da (.clk(clk), .rst(rst), .bus(ia));
    decoder_scan #(.W(2), .DWELL(3)) db (.clk(clk), .rst(rst), .bus(ib));
    decoder_scan #(.W(2), .DWELL(2)) dc (.clk(clk), .rst(rst), .bus(ic));
    decoder_scan #(.W(3), .DWELL(1)) dd (.clk(clk), .rst(rst), .bus(id));

    // Drive one cycle of stimulus and queue the response due after the next edge.
    task automatic step(input int s, input logic r, input logic e, input logic m,
                        input logic [2:0] xv, input logic l, input logic [7:0] ey,
                        input logic [2:0] ei, input logic ew, input string nm);
        exp_t t;
        @(negedge clk);
        rst = r; en = e; mode = m; x = xv; load = l;
        t.sel = s; t.y = ey; t.idx = ei; t.wrap = ew; t.name = nm;
        q.push_back(t);
    endtask

    initial begin : monitor
        exp_t       e;
        logic [7:0] ay;
        logic [2:0] ai;
        logic       aw;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                case (e.sel)
                    0:       begin ay = ia.y;         ai = ia.idx;         aw = ia.wrap; end
                    1:       begin ay = {4'b0, ib.y}; ai = {1'b0, ib.idx}; aw = ib.wrap; end
                    2:       begin ay = {4'b0, ic.y}; ai = {1'b0, ic.idx}; aw = ic.wrap; end
                    default: begin ay = id.y;         ai = id.idx;         aw = id.wrap; end
                endcase
                vectors++;
                if (ay !== e.y || ai !== e.idx || aw !== e.wrap) begin
                    miscompares++;
                    $display("FAIL %s: got y=%h idx=%0d wrap=%b, expected y=%h idx=%0d wrap=%b",
                             e.name, ay, ai, aw, e.y, e.idx, e.wrap);
                end
            end
        end
    end

    initial begin
        // W=3 DWELL=4: reset wins over enabled direct decode, then direct/disable.
        step(0, 0, 1, 0, 5, 0, 8'h00, 0, 0, "a_rst0");
        step(0, 0, 1, 0, 5, 0, 8'h00, 0, 0, "a_rst1");
        step(0, 1, 1, 0, 5, 0, 8'h20, 5, 0, "a_dir5");
        step(0, 1, 0, 0, 2, 0, 8'h00, 5, 0, "a_dis");
        step(0, 1, 1, 0, 2, 0, 8'h04, 2, 0, "a_reen2");
        step(0, 1, 1, 0, 7, 0, 8'h80, 7, 0, "a_dir7");
        step(0, 1, 1, 0, 0, 1, 8'h01, 0, 0, "a_dir0_load");
        // W=2 DWELL=3: load at 2 and scan cadence; x must be ignored while scanning.
        step(1, 0, 1, 0, 0, 0, 8'h00, 0, 0, "b_rst");
        step(1, 1, 1, 1, 2, 1, 8'h04, 2, 0, "b_load2");
        step(1, 1, 1, 1, 1, 0, 8'h04, 2, 0, "b_s2a");
        step(1, 1, 1, 1, 1, 0, 8'h04, 2, 0, "b_s2b");
        step(1, 1, 1, 1, 1, 0, 8'h08, 3, 0, "b_s3a");
        step(1, 1, 1, 1, 1, 0, 8'h08, 3, 0, "b_s3b");
        step(1, 1, 1, 1, 1, 0, 8'h08, 3, 0, "b_s3c");
        step(1, 1, 1, 1, 1, 0, 8'h01, 0, 1, "b_wrap");
        step(1, 1, 1, 1, 1, 0, 8'h01, 0, 0, "b_s0b");
        step(1, 1, 1, 1, 1, 0, 8'h01, 0, 0, "b_s0c");
        step(1, 1, 1, 1, 1, 0, 8'h02, 1, 0, "b_s1a");
        step(1, 1, 1, 1, 1, 0, 8'h02, 1, 0, "b_s1b");
        // Freeze at dcnt=1 for 5 cycles, with a load that must be ignored.
        for (int i = 0; i < 5; i++)
            step(1, 1, 0, 1, 3, i == 2, 8'h00, 1, 0, "b_frz");
        step(1, 1, 1, 1, 1, 0, 8'h02, 1, 0, "b_s1c");
        step(1, 1, 1, 1, 1, 0, 8'h04, 2, 0, "b_s2_after");
        step(1, 1, 1, 0, 3, 0, 8'h08, 3, 0, "b_dir3");
        step(1, 1, 1, 1, 0, 0, 8'h08, 3, 0, "b_sw_a");
        step(1, 1, 1, 1, 0, 0, 8'h08, 3, 0, "b_sw_b");
        step(1, 1, 1, 1, 0, 0, 8'h01, 0, 1, "b_sw_wrap");
        // W=2 DWELL=2: load on a rollover boundary wins and suppresses wrap.
        step(2, 0, 1, 0, 0, 0, 8'h00, 0, 0, "c_rst");
        step(2, 1, 1, 1, 3, 1, 8'h08, 3, 0, "c_load3");
        step(2, 1, 1, 1, 0, 0, 8'h08, 3, 0, "c_s3b");
        step(2, 1, 1, 1, 1, 1, 8'h02, 1, 0, "c_load_bnd");
        step(2, 1, 1, 1, 0, 0, 8'h02, 1, 0, "c_s1b");
        step(2, 1, 1, 1, 0, 0, 8'h04, 2, 0, "c_s2");
        // W=3 DWELL=1: direct 6 then scan every cycle through the rollover.
        step(3, 0, 1, 0, 0, 0, 8'h00, 0, 0, "d_rst");
        step(3, 1, 1, 0, 6, 0, 8'h40, 6, 0, "d_dir6");
        step(3, 1, 1, 1, 0, 0, 8'h80, 7, 0, "d_s7");
        step(3, 1, 1, 1, 0, 0, 8'h01, 0, 1, "d_wrap");
        step(3, 1, 1, 1, 0, 0, 8'h02, 1, 0, "d_s1");
        step(3, 1, 1, 1, 0, 0, 8'h04, 2, 0, "d_s2");
        step(3, 0, 1, 1, 0, 0, 8'h00, 0, 0, "d_rst_mid");
        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected responses never checked, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
